// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell.
// Used by serial_adder as the bit slice that processes one operand bit pair per clock.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder processes one bit pair per clock, LSB first,
// with the carry held in a flop between bits. The result appears WIDTH clocks after start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .A   (a_sh_q[0]),
        .B   (b_sh_q[0]),
        .Cin (carry_q),
        .Sum (fa_sum),
        .Cout(fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    s_sh_d  = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed scenarios plus randomized operands on an 8-bit and a
// 2-bit instance, checked against plain integer addition and the expected start-to-done latency.
module tb_serial_adder;

    localparam int W    = 8;
    localparam int LAT  = W + 1;   // negedges from the start-driving negedge to done visible
    localparam int W2   = 2;
    localparam int LAT2 = W2 + 1;
    localparam int LIMIT = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic          start2, cin2;
    logic [W2-1:0] a2, b2;
    logic          busy2, done2, cout2;
    logic [W2-1:0] sum2;

    int   total  = 0;
    int   passed = 0;
    int   cycles;
    logic busy_gap, held_bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    serial_adder #(.WIDTH(W2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start2),
        .a    (a2),
        .b    (b2),
        .cin  (cin2),
        .busy (busy2),
        .done (done2),
        .sum  (sum2),
        .cout (cout2)
    );

    // Reference: exact unsigned (W+1)-bit sum.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Present operands and a one-cycle start; operands are scrambled right after the edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // Bounded wait for done; records busy gaps and any result movement while waiting.
    task automatic wait_done(input int first);
        logic [W:0] held;
        cycles   = first;
        busy_gap = 1'b0;
        held_bad = 1'b0;
        held     = {cout, sum};
        while (done !== 1'b1 && cycles < LIMIT) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            if ({cout, sum} !== held) held_bad = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if ({cout, sum} !== 9'h000) $display("FAIL reset_result: got %h expected 000", {cout, sum}); else passed++;
        total++; if ({busy2, done2, cout2, sum2} !== 5'b0) $display("FAIL reset_w2: got %b expected 00000", {busy2, done2, cout2, sum2}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        launch(8'h00, 8'h00, 1'b0);
        total++; if (busy !== 1'b1) $display("FAIL zero_busy_rise: got %b expected 1", busy); else passed++;
        wait_done(1);
        total++; if (cycles !== LAT) $display("FAIL zero_latency: got %0d expected %0d", cycles, LAT); else passed++;
        total++; if (busy_gap !== 1'b0) $display("FAIL zero_busy_hold: busy dropped early, got %b expected 0", busy_gap); else passed++;
        total++; if ({busy, cout, sum} !== 10'h000) $display("FAIL zero_result: got busy/cout/sum %h expected 000", {busy, cout, sum}); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b expected 0", done); else passed++;
    endtask

    task automatic test_ripple();
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(1);
        total++; if (cycles !== LAT) $display("FAIL ripple_latency: got %0d expected %0d", cycles, LAT); else passed++;
        total++; if ({cout, sum} !== 9'h100) $display("FAIL ripple_result: got %h expected 100", {cout, sum}); else passed++;
    endtask

    task automatic test_operand_change();
        launch(8'h3C, 8'h0F, 1'b1);
        a = 8'hAA; b = 8'hAA;
        wait_done(1);
        total++; if ({cout, sum} !== model_add(8'h3C, 8'h0F, 1'b1)) $display("FAIL opchg_result: got %h expected %h", {cout, sum}, model_add(8'h3C, 8'h0F, 1'b1)); else passed++;
        total++; if (sum !== 8'h4C) $display("FAIL opchg_sum: got %h expected 4c", sum); else passed++;
    endtask

    task automatic test_start_while_busy();
        int pulses;
        launch(8'h80, 8'h80, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h00; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);
        total++; if (cycles !== LAT) $display("FAIL busy_ignore_latency: got %0d expected %0d", cycles, LAT); else passed++;
        total++; if ({cout, sum} !== 9'h100) $display("FAIL busy_ignore_result: got %h expected 100", {cout, sum}); else passed++;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL busy_ignore_extra_done: got %0d pulses expected 0", pulses); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        launch(8'hFF, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if ({busy, done, cout, sum} !== 11'h000) $display("FAIL midrst_state: got busy/done/cout/sum %h expected 000", {busy, done, cout, sum}); else passed++;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); else passed++;
        launch(8'h01, 8'h02, 1'b0);
        wait_done(1);
        total++; if (cycles !== LAT) $display("FAIL midrst_next_latency: got %0d expected %0d", cycles, LAT); else passed++;
        total++; if ({cout, sum} !== 9'h003) $display("FAIL midrst_next_result: got %h expected 003", {cout, sum}); else passed++;
    endtask

    task automatic test_back_to_back();
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(1);
        total++; if ({cout, sum} !== 9'h080) $display("FAIL b2b_first: got %h expected 080", {cout, sum}); else passed++;
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept: got busy/done %b expected 10", {busy, done}); else passed++;
        wait_done(1);
        total++; if (cycles !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", cycles, LAT); else passed++;
        total++; if (held_bad !== 1'b0) $display("FAIL b2b_held: result moved during run, got %b expected 0", held_bad); else passed++;
        total++; if ({cout, sum} !== 9'h1FE) $display("FAIL b2b_second: got %h expected 1fe", {cout, sum}); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp;
        int           first;
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = model_add(ra, rb, rc);
            launch(ra, rb, rc);
            first = 1;
            if ($urandom_range(0, 3) == 0) begin
                a = W'($urandom); b = W'($urandom); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                first = 2;
            end
            wait_done(first);
            total++; if (cycles !== LAT) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, cycles, LAT); else passed++;
            total++; if ({cout, sum} !== exp) $display("FAIL rand_result[%0d]: %h+%h+%b got %h expected %h", i, ra, rb, rc, {cout, sum}, exp); else passed++;
        end
    endtask

    task automatic test_width2();
        logic [W2-1:0] ra, rb;
        logic          rc;
        logic [W2:0]   exp;
        int            c;
        for (int i = 0; i < 60; i++) begin
            ra = W2'($urandom); rb = W2'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {{W2{1'b0}}, rc};
            @(negedge clk);
            a2 = ra; b2 = rb; cin2 = rc; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; a2 = W2'($urandom); b2 = W2'($urandom);
            c = 1;
            while (done2 !== 1'b1 && c < LIMIT) begin
                @(negedge clk);
                c++;
            end
            total++; if (c !== LAT2) $display("FAIL w2_latency[%0d]: got %0d expected %0d", i, c, LAT2); else passed++;
            total++; if ({cout2, sum2} !== exp) $display("FAIL w2_result[%0d]: %h+%h+%b got %h expected %h", i, ra, rb, rc, {cout2, sum2}, exp); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ripple();
        test_operand_change();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_width2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
